// File: rtl/pmem_round_robin_arbiter_pkg.sv
// Shared types for the L1I/L1D -> pmem round-robin arbiter.
//   lc3b_word   : 16-bit line address
//   lc3b_chunk  : 128-bit cache line
//   arb_state_t : arbiter FSM state
//   arb_owner_t : which cache owns (or last owned) the pmem port
package pmem_round_robin_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_chunk;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RECOVER = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/pmem_round_robin_arbiter_wdog.sv
// Grant watchdog for the pmem arbiter. Counts grant cycles that pass without a
// pmem response and flags the cycle on which the grant has waited Cycles cycles.
// Ports:
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   active_i : arbiter is in a grant state; counter is cleared whenever low
//   resp_i   : pmem response this cycle (suppresses the increment)
//   expire_o : terminal grant cycle reached (combinational, gated by active_i)
module pmem_arb_wdog #(
  parameter int unsigned Cycles = 255,
  parameter int unsigned Width  = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic resp_i,
  output logic expire_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!active_i) begin
      cnt_d = '0;
    end else if (!resp_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds (grant cycle number - 1), so this fires on grant cycle Cycles.
  assign expire_o = active_i && (cnt_q == Width'(Cycles - 1));

endmodule

// File: rtl/pmem_round_robin_arbiter.sv
// Registered round-robin arbiter sharing the physical-memory port between the
// L1 instruction and L1 data caches. The winner's address/data/command are
// latched on grant and held until pmem_resp; the response is routed only to the
// owning cache. On contention the cache not recorded in last_grant wins.
// Optional watchdog: define PMEM_ARB_WDOG_EN to abort grants that wait
// WDOG_CYCLES cycles without pmem_resp (pulses arb_timeout and L1x_resp).
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   L1I_address, L1I_read      : I-cache request (level, held until L1I_resp)
//   L1D_address, L1D_data,
//   L1D_read, L1D_write        : D-cache request (level, held until L1D_resp)
//   pmem_resp                  : pmem completion pulse
//   pmem_read, pmem_write      : registered pmem command
//   address_to_pmem            : registered latched address
//   data_to_pmem               : registered latched write data
//   L1I_resp, L1D_resp         : completion to the owning cache
//   arb_timeout                : one-cycle watchdog abort pulse (0 if disabled)
module pmem_round_robin_arbiter
  import pmem_round_robin_arbiter_pkg::*;
#(
  parameter int unsigned WDOG_CYCLES = 255,
  parameter int unsigned WDOG_W      = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  lc3b_word  L1I_address,
  input  logic      L1I_read,
  input  lc3b_word  L1D_address,
  input  lc3b_chunk L1D_data,
  input  logic      L1D_read,
  input  logic      L1D_write,
  input  logic      pmem_resp,
  output logic      pmem_read,
  output logic      pmem_write,
  output lc3b_word  address_to_pmem,
  output lc3b_chunk data_to_pmem,
  output logic      L1I_resp,
  output logic      L1D_resp,
  output logic      arb_timeout
);

  arb_state_t state_q, state_d;
  arb_owner_t last_grant_q, last_grant_d;
  lc3b_word   addr_q, addr_d;
  lc3b_chunk  data_q, data_d;
  logic       read_q, read_d;
  logic       write_q, write_d;

  logic i_req, d_req, in_grant, wdog_expire;

  assign i_req    = L1I_read;
  assign d_req    = L1D_read | L1D_write;
  assign in_grant = (state_q == GRANT_I) || (state_q == GRANT_D);

`ifdef PMEM_ARB_WDOG_EN
  pmem_arb_wdog #(
    .Cycles (WDOG_CYCLES),
    .Width  (WDOG_W)
  ) u_wdog (
    .clk_i    (clk),
    .rst_i    (rst),
    .active_i (in_grant),
    .resp_i   (pmem_resp),
    .expire_o (wdog_expire)
  );

  // A real response on the terminal cycle is a normal completion.
  assign arb_timeout = wdog_expire & ~pmem_resp;
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = ^{WDOG_CYCLES, WDOG_W, in_grant};
  assign wdog_expire     = 1'b0;
  assign arb_timeout     = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    data_d       = data_q;
    read_d       = read_q;
    write_d      = write_q;
    L1I_resp     = 1'b0;
    L1D_resp     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // I wins when alone or when D held the port last; otherwise D if asking.
        if (i_req && (!d_req || (last_grant_q == OWNER_D))) begin
          state_d      = GRANT_I;
          last_grant_d = OWNER_I;
          addr_d       = L1I_address;
          read_d       = 1'b1;
          write_d      = 1'b0;
        end else if (d_req) begin
          state_d      = GRANT_D;
          last_grant_d = OWNER_D;
          addr_d       = L1D_address;
          data_d       = L1D_data;
          // Read and write together is illegal; write takes precedence.
          write_d      = L1D_write;
          read_d       = ~L1D_write;
        end
      end
      GRANT_I: begin
        if (pmem_resp || wdog_expire) begin
          L1I_resp = 1'b1;
          read_d   = 1'b0;
          write_d  = 1'b0;
          state_d  = RECOVER;
        end
      end
      GRANT_D: begin
        if (pmem_resp || wdog_expire) begin
          L1D_resp = 1'b1;
          read_d   = 1'b0;
          write_d  = 1'b0;
          state_d  = RECOVER;
        end
      end
      RECOVER: begin
        // The served cache is still dropping its request; don't sample it.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= OWNER_D;
      addr_q       <= '0;
      data_q       <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      read_q       <= read_d;
      write_q      <= write_d;
    end
  end

  assign pmem_read       = read_q;
  assign pmem_write      = write_q;
  assign address_to_pmem = addr_q;
  assign data_to_pmem    = data_q;

endmodule

// File: tb/tb_pmem_round_robin_arbiter.sv
// Self-checking bench for pmem_round_robin_arbiter. Expected pmem commands are
// queued when requests are raised and popped when the DUT issues a command.
module tb_pmem_round_robin_arbiter;

`ifdef PMEM_ARB_WDOG_EN
  localparam int unsigned TbWdog  = 4;
  localparam int          LongLat = 3;
`else
  localparam int unsigned TbWdog  = 255;
  localparam int          LongLat = 5;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  L1I_address, L1D_address, address_to_pmem;
  logic [127:0] L1D_data, data_to_pmem;
  logic         L1I_read, L1D_read, L1D_write, pmem_resp;
  logic         pmem_read, pmem_write, L1I_resp, L1D_resp, arb_timeout;

  always #5 clk = ~clk;

  pmem_round_robin_arbiter #(
    .WDOG_CYCLES (TbWdog),
    .WDOG_W      (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .L1I_address     (L1I_address),
    .L1I_read        (L1I_read),
    .L1D_address     (L1D_address),
    .L1D_data        (L1D_data),
    .L1D_read        (L1D_read),
    .L1D_write       (L1D_write),
    .pmem_resp       (pmem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .address_to_pmem (address_to_pmem),
    .data_to_pmem    (data_to_pmem),
    .L1I_resp        (L1I_resp),
    .L1D_resp        (L1D_resp),
    .arb_timeout     (arb_timeout)
  );

  typedef struct {
    bit           is_d;
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] data;
  } exp_cmd_t;

  exp_cmd_t     exp_q[$];
  logic [127:0] model_data = '0;  // last D line latched, held across I grants
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_i(input logic [15:0] a);
    exp_cmd_t e;
    e = '{is_d: 1'b0, wr: 1'b0, addr: a, data: model_data};
    exp_q.push_back(e);
  endtask

  task automatic push_d(input bit wr, input logic [15:0] a, input logic [127:0] d);
    exp_cmd_t e;
    e = '{is_d: 1'b1, wr: wr, addr: a, data: d};
    exp_q.push_back(e);
    model_data = d;
  endtask

  // Wait for the next command, compare it with the scoreboard head, respond on
  // grant cycle lat and check response routing and command release.
  task automatic serve(input int lat, input int exp_wait, input bit drop, input bit perturb);
    int       waited;
    exp_cmd_t e;
    waited = 0;
    while (!(pmem_read || pmem_write) && waited < 20) begin
      tick();
      waited++;
    end
    if (!(pmem_read || pmem_write)) begin
      check_eq("cmd_seen", 0, 1);
      return;
    end
    if (exp_q.size() == 0) begin
      check_eq("sb_nonempty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    if (exp_wait >= 0) check_eq("cmd_latency", waited, exp_wait);
    check_eq("pmem_read", pmem_read, !e.wr);
    check_eq("pmem_write", pmem_write, e.wr);
    check_eq("addr", address_to_pmem, e.addr);
    check_eq("data", data_to_pmem, e.data);
    if (perturb) begin
      L1D_data    = ~L1D_data;
      L1D_address = ~L1D_address;
      L1I_address = ~L1I_address;
    end
    repeat (lat - 1) tick();
    check_eq("addr_hold", address_to_pmem, e.addr);
    check_eq("data_hold", data_to_pmem, e.data);
    check_eq("cmd_hold", {pmem_read, pmem_write}, {!e.wr, e.wr});
    pmem_resp = 1'b1;
    #1;
    check_eq("resp_i_route", L1I_resp, !e.is_d);
    check_eq("resp_d_route", L1D_resp, e.is_d);
    check_eq("no_timeout", arb_timeout, 0);
    tick();
    pmem_resp = 1'b0;
    #1;
    check_eq("cmd_release", {pmem_read, pmem_write}, 0);
    check_eq("resp_release", {L1I_resp, L1D_resp}, 0);
    if (drop) begin
      if (e.is_d) begin
        L1D_read  = 1'b0;
        L1D_write = 1'b0;
      end else begin
        L1I_read = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst         = 1'b1;
    L1I_address = '0;
    L1I_read    = 1'b0;
    L1D_address = '0;
    L1D_data    = '0;
    L1D_read    = 1'b0;
    L1D_write   = 1'b0;
    pmem_resp   = 1'b0;
    tick();
    tick();
    check_eq("rst_cmd", {pmem_read, pmem_write}, 0);
    check_eq("rst_addr", address_to_pmem, 0);
    check_eq("rst_data", data_to_pmem, 0);
    check_eq("rst_resp", {L1I_resp, L1D_resp, arb_timeout}, 0);
    rst = 1'b0;
    tick();

    // Single I read, then an immediate re-request (earliest at r+3).
    L1I_address = 16'h1230;
    L1I_read    = 1'b1;
    push_i(16'h1230);
    serve(LongLat, 1, 1'b1, 1'b0);
    L1I_address = 16'h2240;
    L1I_read    = 1'b1;
    push_i(16'h2240);
    serve(2, 2, 1'b1, 1'b0);
    tick();

    // D write with inputs disturbed mid-grant, then D read, then I read.
    L1D_address = 16'h4000;
    L1D_data    = {16{8'hA5}};
    L1D_write   = 1'b1;
    push_d(1'b1, 16'h4000, {16{8'hA5}});
    serve(3, 1, 1'b1, 1'b1);
    tick();
    L1D_address = 16'h5550;
    L1D_data    = {4{32'hDEAD_BEEF}};
    L1D_read    = 1'b1;
    push_d(1'b0, 16'h5550, {4{32'hDEAD_BEEF}});
    serve(2, 1, 1'b1, 1'b0);
    tick();
    L1I_address = 16'h0abc;
    L1I_read    = 1'b1;
    push_i(16'h0abc);
    serve(2, 1, 1'b1, 1'b0);
    tick();

    // Contention from reset, both held: I, D, I, D.
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    model_data = '0;
    L1I_address = 16'h1000;
    L1I_read    = 1'b1;
    L1D_address = 16'h2000;
    L1D_data    = {8{16'h5a5a}};
    L1D_read    = 1'b1;
    push_i(16'h1000);
    push_d(1'b0, 16'h2000, {8{16'h5a5a}});
    push_i(16'h1000);
    push_d(1'b0, 16'h2000, {8{16'h5a5a}});
    serve(2, 1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) serve(2, 2, 1'b0, 1'b0);
    L1I_read = 1'b0;
    L1D_read = 1'b0;
    tick();
    tick();

    // pmem_resp in IDLE is ignored and the FSM stays idle.
    pmem_resp = 1'b1;
    #1;
    check_eq("idle_resp", {L1I_resp, L1D_resp}, 0);
    tick();
    pmem_resp = 1'b0;
    L1I_address = 16'h0777;
    L1I_read    = 1'b1;
    push_i(16'h0777);
    serve(2, 1, 1'b1, 1'b0);
    tick();

    // Reset during GRANT_D aborts silently; next tie goes to I.
    L1D_address = 16'h7000;
    L1D_data    = {2{64'h0123_4567_89ab_cdef}};
    L1D_write   = 1'b1;
    tick();
    check_eq("rstd_cmd", pmem_write, 1);
    tick();
    rst = 1'b1;
    tick();
    check_eq("rstd_cmd_clr", {pmem_read, pmem_write}, 0);
    check_eq("rstd_addr_clr", address_to_pmem, 0);
    check_eq("rstd_data_clr", data_to_pmem, 0);
    check_eq("rstd_no_resp", {L1I_resp, L1D_resp, arb_timeout}, 0);
    rst        = 1'b0;
    model_data = '0;
    L1I_address = 16'h3000;
    L1I_read    = 1'b1;
    push_i(16'h3000);
    push_d(1'b1, 16'h7000, {2{64'h0123_4567_89ab_cdef}});
    serve(2, 1, 1'b1, 1'b0);
    serve(2, 2, 1'b1, 1'b0);
    tick();

`ifdef PMEM_ARB_WDOG_EN
    // No response: abort on grant cycle 4, then response on the terminal cycle.
    begin
      int w;
      L1I_address = 16'h6000;
      L1I_read    = 1'b1;
      w = 0;
      while (!pmem_read && w < 20) begin
        tick();
        w++;
      end
      check_eq("wd_cmd", pmem_read, 1);
      repeat (3) tick();
      check_eq("wd_timeout", arb_timeout, 1);
      check_eq("wd_resp", {L1I_resp, L1D_resp}, 2'b10);
      tick();
      check_eq("wd_timeout_pulse", arb_timeout, 0);
      check_eq("wd_cmd_drop", pmem_read, 0);
      L1I_read = 1'b0;
      tick();
      tick();
      L1I_address = 16'h6100;
      L1I_read    = 1'b1;
      push_i(16'h6100);
      serve(4, 1, 1'b1, 1'b0);
      tick();
    end
`endif

    check_eq("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pmem_round_robin_arbiter.md
# pmem_round_robin_arbiter

Registered round-robin arbiter sharing the single physical-memory port between the L1 instruction and L1 data caches. Latches the winning request's address and write data, holds them stable for the whole pmem transaction, and routes `pmem_resp` back to the granted cache only. Alternates priority on contention so neither cache starves. Sits between both L1 controllers and pmem, replacing direct combinational selection.

## Interface
- `WDOG_CYCLES`, default 255: cycles a grant may wait for `pmem_resp` before the watchdog aborts it. Used only with the watchdog compiled in.
- `WDOG_W`, default 8: watchdog counter width. Must satisfy 2^WDOG_W > WDOG_CYCLES.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `L1I_address`  in  16 (`lc3b_word`)  I-cache line address.
- `L1I_read`  in  1  I-cache read request, level, held until `L1I_resp`.
- `L1D_address`  in  16 (`lc3b_word`)  D-cache line address.
- `L1D_data`  in  128 (`lc3b_chunk`)  D-cache write-back line.
- `L1D_read` / `L1D_write`  in  1 each  D-cache requests, level, held until `L1D_resp`.
- `pmem_resp`  in  1  pmem completion pulse.
- `pmem_read` / `pmem_write`  out  1 each  registered pmem command.
- `address_to_pmem`  out  16  registered latched address.
- `data_to_pmem`  out  128  registered latched write data.
- `L1I_resp` / `L1D_resp`  out  1 each  completion to the owning cache.
- `arb_timeout`  out  1  one-cycle pulse when the watchdog aborts a grant.

## Operation
- States: IDLE, GRANT_I, GRANT_D, RECOVER.
- **IDLE** samples requests.
  - I-cache requests only (`L1I_read`): go to GRANT_I.
  - D-cache requests only (`L1D_read | L1D_write`): go to GRANT_D.
  - Both request: grant the requester not recorded in `last_grant`.
  - Neither requests: stay in IDLE.
- **On a grant:**
  - Latch the winner's address into `address_to_pmem`.
  - Latch `L1D_data` into `data_to_pmem` for D grants; `data_to_pmem` holds its previous value for I grants.
  - Update `last_grant`.
- **D-side command:**
  - `L1D_write` gives `pmem_write`.
  - `L1D_read` gives `pmem_read`.
  - Both asserted is illegal; write wins.
  - I grants always issue `pmem_read`.
- **GRANT_x** holds the command and latched address/data constant until `pmem_resp`.
  - `L1x_resp = pmem_resp`, combinational, in the same cycle.
  - Next state is RECOVER; command deasserts on that edge.
- **RECOVER** lasts exactly one cycle.
  - Requests are ignored, because the served cache drops its request during this cycle.
  - Then go to IDLE.
- `pmem_resp` in IDLE or RECOVER is ignored; no `L1x_resp` is produced.
- Requester inputs changing during a grant do not affect pmem outputs.

## Timing
- **Reset values:**
  - Reset sets state IDLE, `pmem_read`/`pmem_write` 0, `address_to_pmem` 0, `data_to_pmem` 0.
  - `L1I_resp`/`L1D_resp` 0, `arb_timeout` 0.
  - `last_grant` = D, so I wins the first tie.
- Reset mid-grant aborts silently: no resp is issued; the requester re-arbitrates after reset.
- Request seen in IDLE at cycle t gives the pmem command at t+1.
- `pmem_resp` at cycle r gives `L1x_resp` at r.
  - The command is low from r+1.
  - State is IDLE at r+2.
  - Earliest next command is at r+3.
- Back-to-back contention alternates strictly: I, D, I, D…
- A single requester re-requesting is served every transaction with no penalty beyond RECOVER.

## Configuration
- `PMEM_ARB_WDOG_EN` defined:
  - A `WDOG_W`-bit counter clears on grant entry and increments each GRANT cycle without `pmem_resp`.
  - On reaching `WDOG_CYCLES`: assert `L1x_resp` and `arb_timeout` for one cycle, drop the command, go to RECOVER.
  - `pmem_resp` arriving on the terminal cycle counts as normal completion; `arb_timeout` stays 0.
- Undefined: no counter; `arb_timeout` tied 0; grants wait indefinitely.

## Structure
- Add to `lc3b_types`:
  - `arb_state_t` enum {IDLE, GRANT_I, GRANT_D, RECOVER}.
  - `arb_owner_t` enum {OWNER_I, OWNER_D}.
- Sub-module `pmem_arb_wdog`: counter plus terminal compare. Instantiated only under `PMEM_ARB_WDOG_EN`.
- Top level holds the FSM, `last_grant` and the address/data/command registers.

## Test plan
- Reset, then `L1I_read`=1 with `L1I_address`=0x1230 → t+1: `pmem_read`=1, `address_to_pmem`=0x1230. `pmem_resp` at t+5 → `L1I_resp`=1 at t+5 only, `pmem_read`=0 at t+6.
- `L1D_write`=1, `L1D_address`=0x4000, `L1D_data`=0xA5 repeated → `pmem_write`=1 with data latched. `L1D_data` changes mid-grant → `data_to_pmem` unchanged.
- I and D request simultaneously from reset, both held continuously → grant order I, D, I, D. Resp pulses go only to the owner.
- `pmem_resp` pulsed in IDLE → no `L1I_resp`/`L1D_resp`, state stays IDLE.
- `rst` asserted during GRANT_D → next cycle all outputs 0, no `L1D_resp`. The next tie goes to I.
- With `PMEM_ARB_WDOG_EN`, `WDOG_CYCLES`=4, no `pmem_resp` → at the 4th grant cycle `arb_timeout`=1 and `L1x_resp`=1; command 0 on the next cycle.
